pos_dump_tx: RTL and testbench
==============================

// Module: pos_dump_tx
// PURPOSE
//  Transmit-side counterpart of the position-init path: after a run, reads every particle
//  out of the per-cell position caches and packs them into 512-bit AXI-Stream beats,
//  NUM_SUB_PACKETS (4) x 128-bit sub-packets per beat, for return to host or peer FPGA.
//  Sits between the pos_cache array (shared read mux) and the outbound streaming port.
// PARAMETERS
//  NUM_CELLS      27   cells scanned, index 0..NUM_CELLS-1 (X*Y_DIM*Z_DIM+Y*Z_DIM+Z)
//  MAX_PER_CELL   128  per-cell count clamp (NUM_PARTICLES_PER_CELL)
//  RD_LATENCY     2    cycles from o_rd_en to i_rd_data valid, fixed
//  FIFO_DEPTH     8    sub-packet FIFO entries, power of 2, >= RD_LATENCY+4
//  DEST           0    constant o_tdest value
// PORTS
//  clk              in   1      clock
//  rst              in   1      asynchronous reset, active-low
//  i_dump_start     in   1      1-cycle pulse, begin dump (ignored while o_busy)
//  i_num_particles  in   27x8   per-cell particle count, sampled on accepted start
//  o_rd_en          out  1      cache read strobe
//  o_rd_cell        out  5      cell index (MU_ID_WIDTH)
//  o_rd_addr        out  7      particle slot within cell
//  i_rd_data        in   86     pos_packet_t {pos,parid,element}, valid RD_LATENCY after o_rd_en
//  o_tdata          out  512    beat; sub-packet k at [128k+127:128k]
//  o_tvalid         out  1      AXIS valid
//  i_tready         in   1      AXIS ready
//  o_tlast          out  1      final beat of dump
//  o_tkeep          out  64     all ones whenever o_tvalid
//  o_tdest          out  16     = DEST
//  o_busy           out  1      high from accepted start until final beat handshake
//  o_done           out  1      1-cycle pulse the cycle after final beat handshake
// BEHAVIOUR
//  Reset: all outputs 0 (o_tdest=DEST); FIFO, counters, in-flight reads discarded; FSM IDLE.
//  Reset mid-dump aborts with no tlast; next dump starts clean from cell 0.
//  Sub-packet: [85:0] pos_packet_t, [90:86] cell index, [126:91] 0, [127] valid flag.
//  FSM IDLE -> READ on start: latch counts, clamp each to MAX_PER_CELL; cell=0, addr=0.
//  READ: per cycle, if count[cell]==0 advance cell (one cycle, no read); else issue read
//    only if (in_flight + fifo_count) < FIFO_DEPTH; addr++, on addr==count-1 advance cell.
//    After last cell -> DRAIN. Never more than FIFO_DEPTH reads outstanding+buffered.
//  Returned data pushed into FIFO exactly RD_LATENCY cycles after its o_rd_en (shift-reg tag
//    carries cell index); FIFO can never overflow by the credit rule.
//  Packer: forms a beat when FIFO holds >=4 entries, or in DRAIN when in_flight==0 and FIFO
//    non-empty (1-3 entries, remaining lanes all-zero with valid bit 0). Lane 0 = oldest.
//  AXIS: once o_tvalid=1, o_tdata/o_tlast held stable until i_tready; one beat per handshake.
//    Output register refills same cycle as handshake (full throughput, 1 beat/cycle possible).
//  o_tlast=1 on the beat that empties the FIFO in DRAIN with in_flight==0.
//  All counts zero: single beat, all lanes invalid, o_tlast=1.
//  DRAIN -> IDLE after tlast handshake; o_busy drops, o_done pulses next cycle.
//  Total sub-packets = sum(clamped counts); beats = ceil(total/4) (min 1).
//  Read-issue latency from start: first o_rd_en 1 cycle after start (if cell 0 non-empty).
// TESTING
//  1 particle/cell, tready=1 -> 7 beats; beat 6 lanes 0-2 valid (cells 24-26), lane 3 zero, tlast on beat 6 only.
//  15 particles/cell (init default) -> 405 sub-packets, 102 beats, last beat lane 0 valid only; parids in order.
//  Same as above with i_tready random 30% low -> identical beat sequence; tdata stable while stalled; no FIFO overflow.
//  All counts 0 -> exactly one beat, tdata=0, tlast=1, o_done pulse next cycle.
//  Counts {200, 0, 3, rest 0} -> cell 0 clamped to 128, cell 1 skipped, 131 sub-packets, 33 beats.
//  Assert rst low mid-dump then restart -> tvalid low immediately, second dump output complete and correct; start while busy ignored.

Source files
------------

// File: rtl/pos_dump_tx.sv
// Position dump transmitter: scans per-cell position caches after a run and packs particles
// into 512-bit AXI-Stream beats of four 128-bit sub-packets, oldest sub-packet in lane 0.
module pos_dump_tx #(
  parameter int unsigned NUM_CELLS    = 27,
  parameter int unsigned MAX_PER_CELL = 128,
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [15:0] DEST         = 16'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_dump_start,
  input  logic [NUM_CELLS*8-1:0] i_num_particles,
  output logic                   o_rd_en,
  output logic [4:0]             o_rd_cell,
  output logic [6:0]             o_rd_addr,
  input  logic [85:0]            i_rd_data,
  output logic [511:0]           o_tdata,
  output logic                   o_tvalid,
  input  logic                   i_tready,
  output logic                   o_tlast,
  output logic [63:0]            o_tkeep,
  output logic [15:0]            o_tdest,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned NumSub = 4;
  localparam int unsigned EntW   = 91;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned FCntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TotW   = $clog2(NUM_CELLS * MAX_PER_CELL + 1);
  localparam int unsigned IfW    = $clog2(RD_LATENCY + 1);
  localparam logic [7:0]  MaxCnt = 8'(MAX_PER_CELL);
  localparam logic [4:0]  LastCell = 5'(NUM_CELLS - 1);
  localparam logic [FCntW:0] DepthW = (FCntW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e             state_q, state_d;
  logic [7:0]         counts_q [NUM_CELLS];
  logic [7:0]         clamped  [NUM_CELLS];
  logic [4:0]         cell_q, cell_d;
  logic [6:0]         addr_q, addr_d;
  logic [TotW-1:0]    total_q, start_total, emitted_q;
  logic [RD_LATENCY-1:0] tag_vld_q;
  logic [4:0]         tag_cell_q [RD_LATENCY];
  logic [IfW-1:0]     in_flight;
  logic [EntW-1:0]    mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [FCntW-1:0]   fcnt_q;
  logic [511:0]       tdata_q, beat;
  logic               tvalid_q, tlast_q, sent_last_q, done_q;
  logic               rd_en, start_acc, credit_ok, push, form, load, is_last, hs, adv;
  logic [2:0]         lanes, pop_n;
  logic [7:0]         cur_cnt;
  logic [EntW-1:0]    ent;

  assign start_acc = i_dump_start && (state_q == StIdle);
  assign cur_cnt   = counts_q[cell_q];
  assign push      = tag_vld_q[RD_LATENCY-1];
  assign hs        = tvalid_q && i_tready;

  always_comb begin
    start_total = '0;
    for (int c = 0; c < NUM_CELLS; c++) begin
      clamped[c]  = (i_num_particles[c*8 +: 8] > MaxCnt) ? MaxCnt : i_num_particles[c*8 +: 8];
      start_total = start_total + TotW'(clamped[c]);
    end
  end

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + IfW'(tag_vld_q[i]);
    end
  end

  // Reads already issued still hold a FIFO slot, so the FIFO can never overflow.
  assign credit_ok = ({1'b0, fcnt_q} + (FCntW + 1)'(in_flight)) < DepthW;

  always_comb begin
    state_d = state_q;
    cell_d  = cell_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    adv     = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_dump_start) begin
          state_d = StRead;
          cell_d  = '0;
          addr_d  = '0;
        end
      end
      StRead: begin
        if (cur_cnt == 8'd0) begin
          adv = 1'b1;
        end else if (credit_ok) begin
          rd_en = 1'b1;
          if ({1'b0, addr_q} == cur_cnt - 8'd1) begin
            addr_d = '0;
            adv    = 1'b1;
          end else begin
            addr_d = addr_q + 7'd1;
          end
        end
        if (adv) begin
          if (cell_q == LastCell) state_d = StDrain;
          else                    cell_d  = cell_q + 5'd1;
        end
      end
      StDrain: ;
      default: state_d = StIdle;
    endcase
    // The final beat can leave while trailing empty cells are still being scanned.
    if (hs && tlast_q) state_d = StIdle;
  end

  always_comb begin
    lanes   = (fcnt_q >= FCntW'(NumSub)) ? 3'd4 : 3'(fcnt_q);
    // emitted + buffered == total means nothing is in flight or left to read.
    form    = (state_q != StIdle) && !sent_last_q &&
              ((fcnt_q >= FCntW'(NumSub)) || ((emitted_q + TotW'(fcnt_q)) == total_q));
    load    = form && (!tvalid_q || i_tready);
    is_last = (emitted_q + TotW'(lanes)) == total_q;
    pop_n   = load ? lanes : 3'd0;
  end

  always_comb begin
    beat = '0;
    ent  = '0;
    for (int k = 0; k < NumSub; k++) begin
      ent = mem_q[rd_ptr_q + PtrW'(k)];
      if (k < int'(lanes)) beat[128*k +: 128] = {1'b1, 36'b0, ent};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {tag_cell_q[RD_LATENCY-1], i_rd_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cell_q      <= '0;
      addr_q      <= '0;
      total_q     <= '0;
      emitted_q   <= '0;
      tag_vld_q   <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fcnt_q      <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      sent_last_q <= 1'b0;
      done_q      <= 1'b0;
      for (int c = 0; c < NUM_CELLS; c++) counts_q[c] <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_cell_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cell_q  <= cell_d;
      addr_q  <= addr_d;
      done_q  <= hs && tlast_q;

      if (start_acc) begin
        for (int c = 0; c < NUM_CELLS; c++) counts_q[c] <= clamped[c];
        total_q     <= start_total;
        emitted_q   <= '0;
        sent_last_q <= 1'b0;
      end else if (load) begin
        emitted_q <= emitted_q + TotW'(lanes);
        if (is_last) sent_last_q <= 1'b1;
      end

      tag_vld_q[0]  <= rd_en;
      tag_cell_q[0] <= cell_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_cell_q[i] <= tag_cell_q[i-1];
      end

      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      rd_ptr_q <= rd_ptr_q + PtrW'(pop_n);
      fcnt_q   <= fcnt_q + FCntW'(push) - FCntW'(pop_n);

      if (load) begin
        tdata_q  <= beat;
        tvalid_q <= 1'b1;
        tlast_q  <= is_last;
      end else if (hs) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
    end
  end

  assign o_rd_en   = rd_en;
  assign o_rd_cell = cell_q;
  assign o_rd_addr = addr_q;
  assign o_tdata   = tdata_q;
  assign o_tvalid  = tvalid_q;
  assign o_tlast   = tlast_q;
  assign o_tkeep   = {64{tvalid_q}};
  assign o_tdest   = DEST;
  assign o_busy    = (state_q != StIdle);
  assign o_done    = done_q;

endmodule

// File: tb/tb_pos_dump_tx.sv
// Bench for pos_dump_tx: behavioural cache with fixed read latency and a sub-packet-list
// reference model for the expected beat stream.
module tb_pos_dump_tx;
  localparam int NC = 27;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_dump_start = 1'b0;
  logic [NC*8-1:0] i_num_particles = '0;
  logic          o_rd_en;
  logic [4:0]    o_rd_cell;
  logic [6:0]    o_rd_addr;
  logic [85:0]   i_rd_data = '0;
  logic [511:0]  o_tdata;
  logic          o_tvalid;
  logic          i_tready = 1'b1;
  logic          o_tlast;
  logic [63:0]   o_tkeep;
  logic [15:0]   o_tdest;
  logic          o_busy;
  logic          o_done;

  int checks = 0;
  int errors = 0;
  int cnts [NC];
  logic [31:0] salt = 32'h1234_5678;
  logic [511:0] exp_beats [$];

  logic       req_v = 1'b0;
  logic [4:0] req_c = '0;
  logic [6:0] req_a = '0;

  pos_dump_tx dut (
    .clk             (clk),
    .rst             (rst),
    .i_dump_start    (i_dump_start),
    .i_num_particles (i_num_particles),
    .o_rd_en         (o_rd_en),
    .o_rd_cell       (o_rd_cell),
    .o_rd_addr       (o_rd_addr),
    .i_rd_data       (i_rd_data),
    .o_tdata         (o_tdata),
    .o_tvalid        (o_tvalid),
    .i_tready        (i_tready),
    .o_tlast         (o_tlast),
    .o_tkeep         (o_tkeep),
    .o_tdest         (o_tdest),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  always #5 clk = ~clk;

  // Contents of slot a in cell c; parid field is c*128+a so order is visible.
  function automatic logic [85:0] cache_word(int c, int a);
    logic [31:0] h;
    h = (32'(c * 128 + a) * 32'h9E37_79B1) ^ salt;
    return {h, 22'(c * 128 + a), (h ^ 32'h5A5A_1234) + salt};
  endfunction

  // Two-cycle read latency: request captured, then data presented for one cycle.
  always @(posedge clk) begin
    req_v     <= o_rd_en;
    req_c     <= o_rd_cell;
    req_a     <= o_rd_addr;
    i_rd_data <= req_v ? cache_word(int'(req_c), int'(req_a)) : {$urandom, $urandom, $urandom};
  end

  function automatic int clampc(int v);
    return (v > 128) ? 128 : v;
  endfunction

  task automatic build_expected();
    logic [127:0] sp [$];
    logic [511:0] b;
    int n, nb;
    exp_beats.delete();
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < clampc(cnts[c]); a++)
        sp.push_back({1'b1, 36'b0, 5'(c), cache_word(c, a)});
    n  = sp.size();
    nb = (n == 0) ? 1 : (n + 3) / 4;
    for (int i = 0; i < nb; i++) begin
      b = '0;
      for (int k = 0; k < 4; k++)
        if (4 * i + k < n) b[128*k +: 128] = sp[4*i+k];
      exp_beats.push_back(b);
    end
  endtask

  task automatic apply_counts();
    for (int c = 0; c < NC; c++) i_num_particles[c*8 +: 8] = 8'(cnts[c]);
  endtask

  // Runs one dump, checking every beat; nb_req < 0 skips the fixed beat-count check.
  task automatic run_dump(input string name, input int stall_pct, input bit poke, input int nb_req);
    int idx = 0;
    bit prev_stall = 0, prev_last = 0, fin = 0, last_hs = 0;
    logic [511:0] prev_data = '0;
    salt = $urandom;
    build_expected();
    @(negedge clk);
    apply_counts();
    i_dump_start = 1'b1;
    i_tready     = 1'b1;
    @(negedge clk);
    i_dump_start = 1'b0;
    checks++;
    if (o_rd_en !== (cnts[0] != 0)) begin
      errors++;
      $display("FAIL %s first_rd_en: got %b want %b", name, o_rd_en, cnts[0] != 0);
    end
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b want 1", name, o_busy);
    end
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      i_dump_start = 1'b0;
      if (last_hs) begin
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
          errors++;
          $display("FAIL %s done_pulse: done=%b busy=%b want done=1 busy=0", name, o_done, o_busy);
        end
        fin = 1;
      end else begin
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_window: done=%b busy=%b want done=0 busy=1", name, o_done, o_busy);
        end
        if (prev_stall) begin
          checks++;
          if (o_tvalid !== 1'b1 || o_tdata !== prev_data || o_tlast !== prev_last) begin
            errors++;
            $display("FAIL %s stall_stable: valid=%b last=%b want held beat", name, o_tvalid, o_tlast);
          end
        end
        if (poke && cyc == 10) begin
          i_dump_start = 1'b1;
          for (int c = 0; c < NC; c++) i_num_particles[c*8 +: 8] = 8'($urandom_range(255));
        end
        i_tready = ($urandom_range(99) >= stall_pct);
        if (o_tvalid) begin
          checks++;
          if (o_tkeep !== {64{1'b1}} || o_tdest !== 16'd0) begin
            errors++;
            $display("FAIL %s keep_dest: keep=%h dest=%h want all-ones/0", name, o_tkeep, o_tdest);
          end
          if (i_tready) begin
            checks++;
            if (idx >= exp_beats.size()) begin
              errors++;
              $display("FAIL %s extra_beat: beat %0d beyond %0d", name, idx, exp_beats.size());
            end else if (o_tdata !== exp_beats[idx] || o_tlast !== (idx == exp_beats.size() - 1)) begin
              errors++;
              $display("FAIL %s beat%0d: got last=%b data=%h want last=%b data=%h", name, idx,
                       o_tlast, o_tdata, idx == exp_beats.size() - 1, exp_beats[idx]);
            end
            idx++;
            if (o_tlast) last_hs = 1;
          end
          prev_stall = !i_tready;
          prev_data  = o_tdata;
          prev_last  = o_tlast;
        end else begin
          prev_stall = 0;
        end
      end
    end
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout: got %0d beats, no tlast handshake", name, idx);
    end
    checks++;
    if (idx != exp_beats.size() || (nb_req >= 0 && idx != nb_req)) begin
      errors++;
      $display("FAIL %s beat_count: got %0d want %0d", name, idx, exp_beats.size());
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: done=%b valid=%b want 0 0", name, o_done, o_tvalid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_tvalid !== 1'b0 || o_tlast !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 ||
        o_rd_en !== 1'b0 || o_tdata !== '0 || o_tkeep !== '0 || o_tdest !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b last=%b busy=%b done=%b rd=%b want all 0",
               o_tvalid, o_tlast, o_busy, o_done, o_rd_en);
    end
    rst = 1'b1;
  endtask

  task automatic test_one_per_cell();
    for (int c = 0; c < NC; c++) cnts[c] = 1;
    run_dump("one_per_cell", 0, 0, 7);
  endtask

  task automatic test_default_15();
    for (int c = 0; c < NC; c++) cnts[c] = 15;
    run_dump("default_15", 0, 0, 102);
  endtask

  task automatic test_stall_and_busy_start();
    for (int c = 0; c < NC; c++) cnts[c] = 15;
    run_dump("stall_30", 30, 1, 102);
  endtask

  task automatic test_all_zero();
    for (int c = 0; c < NC; c++) cnts[c] = 0;
    run_dump("all_zero", 0, 0, 1);
  endtask

  task automatic test_clamp();
    for (int c = 0; c < NC; c++) cnts[c] = 0;
    cnts[0] = 200;
    cnts[2] = 3;
    run_dump("clamp", 0, 0, 33);
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      for (int c = 0; c < NC; c++)
        cnts[c] = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(6));
      run_dump("random", 50, 0, -1);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < NC; c++) cnts[c] = 15;
    @(negedge clk);
    apply_counts();
    i_dump_start = 1'b1;
    i_tready     = 1'b1;
    @(negedge clk);
    i_dump_start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (o_tvalid !== 1'b0 || o_busy !== 1'b0 || o_tlast !== 1'b0 || o_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b busy=%b last=%b rd=%b want 0", o_tvalid, o_busy, o_tlast,
               o_rd_en);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < NC; c++) cnts[c] = 5 + (c % 4);
    run_dump("after_reset", 20, 0, -1);
  endtask

  initial begin
    test_reset();
    test_one_per_cell();
    test_default_15();
    test_stall_and_busy_start();
    test_all_zero();
    test_clamp();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
